// File: rtl/rx_byte_packer_pkg.sv
// Shared types and defaults for the receive byte packer.
// Holds the packer state encoding and the default word/FIFO sizing.
package rx_byte_packer_pkg;

    localparam int DEF_WORD_BYTES = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FLAG_BITS = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_FCS = 2'd2
    } state_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Word FIFO with a registered first-word-fall-through output stage.
// Capacity counts the output register; a pop frees a slot the same cycle.
module rx_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic [AW:0]      total;
    logic             pop;
    logic             load;
    logic             accept;
    logic             from_mem;
    logic             to_mem;

    // Decide whether the output stage refills and where an incoming word goes.
    always_comb begin
        pop      = valid && ready;
        load     = !valid || pop;
        total    = mem_cnt + {{AW{1'b0}}, valid};
        accept   = push && ((total != (AW+1)'(DEPTH)) || pop);
        drop     = push && !accept;
        from_mem = load && (mem_cnt != '0);
        to_mem   = accept && !(load && (mem_cnt == '0));
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (to_mem) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            valid   <= 1'b0;
            dout    <= '0;
        end else begin
            if (to_mem) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (from_mem) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
                valid  <= 1'b1;
            end else if (load) begin
                valid <= accept;
                if (accept) begin
                    dout <= din;
                end
            end
            case ({to_mem, from_mem})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rx_byte_packer.sv
// Packs decoded receiver bytes into little-endian words with packet framing.
// The last word is held until the FCS verdict arrives or a new header aborts it.
module rx_byte_packer
    import rx_byte_packer_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    pkt_header_valid_strobe,
    input  logic                    pkt_header_valid,
    input  logic [15:0]             pkt_len,
    input  logic                    byte_out_strobe,
    input  logic [7:0]              byte_out,
    input  logic                    fcs_out_strobe,
    input  logic                    fcs_ok,
    output logic [8*WORD_BYTES-1:0] m_word,
    output logic [WORD_BYTES-1:0]   m_keep,
    output logic                    m_last,
    output logic                    m_fcs_ok,
    output logic                    m_abort,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    overflow_err
);

    localparam int LW = $clog2(WORD_BYTES);
    localparam int DW = 8 * WORD_BYTES;
    localparam int FW = DW + WORD_BYTES + FLAG_BITS;

    state_t                state;
    logic [15:0]           len_q;
    logic [15:0]           count_q;
    logic [15:0]           count_nxt;
    logic [DW-1:0]         word_q;
    logic [DW-1:0]         wr_word;
    logic [LW:0]           lanes_q;
    logic [LW-1:0]         lane;
    logic [WORD_BYTES-1:0] cur_keep;
    logic [WORD_BYTES-1:0] wr_keep;
    logic                  hdr_ok;
    logic                  is_last;
    logic                  lane_full;
    logic                  push_q;
    logic [FW-1:0]         push_d;
    logic                  fifo_drop;
    logic [FW-1:0]         fifo_dout;
    logic                  ovf_q;

    // Next word image with the incoming byte merged, plus keep masks.
    always_comb begin
        lane      = lanes_q[LW-1:0];
        count_nxt = count_q + 16'd1;
        is_last   = (count_nxt == len_q);
        lane_full = (lane == LW'(WORD_BYTES - 1));
        hdr_ok    = pkt_header_valid_strobe && pkt_header_valid;
        wr_word   = word_q;
        wr_word[{lane, 3'b000} +: 8] = byte_out;
        for (int i = 0; i < WORD_BYTES; i++) begin
            cur_keep[i] = ((LW+1)'(i) < lanes_q);
            wr_keep[i]  = ((LW+1)'(i) <= lanes_q);
        end
    end

    // Packet state machine feeding the single push register.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state   <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
            lanes_q <= '0;
            push_q  <= 1'b0;
            push_d  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
            if (hdr_ok) begin
                if (state != IDLE) begin
                    push_q <= 1'b1;
                    push_d <= {1'b1, 1'b0, 1'b1, cur_keep, word_q};
                end
                word_q  <= '0;
                lanes_q <= '0;
                count_q <= '0;
                if (pkt_len != 16'd0) begin
                    len_q <= pkt_len;
                    ovf_q <= 1'b0;
                    state <= COLLECT;
                end else begin
                    state <= IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    COLLECT: begin
                        if (byte_out_strobe) begin
                            count_q <= count_nxt;
                            if (is_last && fcs_out_strobe) begin
                                push_q  <= 1'b1;
                                push_d  <= {1'b0, fcs_ok, 1'b1,
                                            wr_keep, wr_word};
                                word_q  <= '0;
                                lanes_q <= '0;
                                state   <= IDLE;
                            end else if (is_last) begin
                                word_q  <= wr_word;
                                lanes_q <= lanes_q + (LW+1)'(1);
                                state   <= WAIT_FCS;
                            end else if (lane_full) begin
                                push_q  <= 1'b1;
                                push_d  <= {3'b000,
                                            {WORD_BYTES{1'b1}}, wr_word};
                                word_q  <= '0;
                                lanes_q <= '0;
                            end else begin
                                word_q  <= wr_word;
                                lanes_q <= lanes_q + (LW+1)'(1);
                            end
                        end
                    end
                    WAIT_FCS: begin
                        if (fcs_out_strobe) begin
                            push_q  <= 1'b1;
                            push_d  <= {1'b0, fcs_ok, 1'b1,
                                        cur_keep, word_q};
                            word_q  <= '0;
                            lanes_q <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    rx_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .push  (push_q),
        .din   (push_d),
        .ready (m_ready),
        .valid (m_valid),
        .dout  (fifo_dout),
        .drop  (fifo_drop)
    );

    assign {m_abort, m_fcs_ok, m_last, m_keep, m_word} = fifo_dout;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Self-checking bench for rx_byte_packer with directed and random packets.
// Expected words come from a byte-queue chunking model of packet framing.
module tb_rx_byte_packer;

    localparam int WB = 8;

    typedef struct {
        logic [63:0] word;
        logic [7:0]  keep;
        logic        last;
        logic        fcs;
        logic        abort;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_strobe;
    logic        hdr_valid;
    logic [15:0] pkt_len;
    logic        byte_strobe;
    logic [7:0]  byte_out;
    logic        fcs_strobe;
    logic        fcs_ok;
    logic [63:0] m_word;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_fcs_ok;
    logic        m_abort;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        overflow_err;

    int   n_checks = 0;
    int   n_fail = 0;
    ent_t exp_q[$];
    ent_t got_q[$];
    logic [7:0] pb[$];
    logic ready_fixed = 1'b1;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    rx_byte_packer #(
        .WORD_BYTES (WB),
        .FIFO_DEPTH (4)
    ) dut (
        .s00_axi_aclk            (clk),
        .s00_axi_aresetn         (rst_n),
        .pkt_header_valid_strobe (hdr_strobe),
        .pkt_header_valid        (hdr_valid),
        .pkt_len                 (pkt_len),
        .byte_out_strobe         (byte_strobe),
        .byte_out                (byte_out),
        .fcs_out_strobe          (fcs_strobe),
        .fcs_ok                  (fcs_ok),
        .m_word                  (m_word),
        .m_keep                  (m_keep),
        .m_last                  (m_last),
        .m_fcs_ok                (m_fcs_ok),
        .m_abort                 (m_abort),
        .m_valid                 (m_valid),
        .m_ready                 (m_ready),
        .overflow_err            (overflow_err)
    );

    // Consumer ready, fixed or random.
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    // Record transfers that will complete at the next rising edge.
    always @(negedge clk) begin : mon
        ent_t g;
        if (rst_n && m_valid && m_ready) begin
            g.word  = m_word;
            g.keep  = m_keep;
            g.last  = m_last;
            g.fcs   = m_fcs_ok;
            g.abort = m_abort;
            got_q.push_back(g);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic v, input logic [15:0] l);
        hdr_strobe = 1'b1;
        hdr_valid  = v;
        pkt_len    = l;
        tick();
        hdr_strobe = 1'b0;
        hdr_valid  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_fcs,
                             input logic ok);
        byte_strobe = 1'b1;
        byte_out    = b;
        fcs_strobe  = with_fcs;
        fcs_ok      = ok;
        pb.push_back(b);
        tick();
        byte_strobe = 1'b0;
        fcs_strobe  = 1'b0;
    endtask

    task automatic send_fcs(input logic ok);
        fcs_strobe = 1'b1;
        fcs_ok     = ok;
        tick();
        fcs_strobe = 1'b0;
    endtask

    // Reference framing: chunk the packet's bytes into words.
    task automatic model_close(input logic abort, input logic ok);
        ent_t e;
        int n;
        int nf;
        n = pb.size();
        if (!abort) begin
            for (int i = 0; i < n; i += WB) begin
                e.word = '0;
                e.keep = '0;
                for (int j = 0; j < WB; j++) begin
                    if (i + j < n) begin
                        e.word[8*j +: 8] = pb[i+j];
                        e.keep[j] = 1'b1;
                    end
                end
                e.last  = (i + WB >= n);
                e.fcs   = e.last ? ok : 1'b0;
                e.abort = 1'b0;
                exp_q.push_back(e);
            end
        end else begin
            nf = n / WB;
            for (int w = 0; w <= nf; w++) begin
                e.word = '0;
                e.keep = '0;
                for (int j = 0; j < WB; j++) begin
                    if (w * WB + j < n) begin
                        e.word[8*j +: 8] = pb[w*WB+j];
                        e.keep[j] = 1'b1;
                    end
                end
                e.last  = (w == nf);
                e.fcs   = 1'b0;
                e.abort = (w == nf);
                exp_q.push_back(e);
            end
        end
        pb.delete();
    endtask

    task automatic compare(input string tag);
        int ne;
        for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) begin
            tick();
        end
        repeat (12) tick();
        ne = exp_q.size();
        check({tag, " count"}, 64'(got_q.size()), 64'(ne));
        for (int i = 0; i < ne && i < got_q.size(); i++) begin
            check($sformatf("%s w%0d word", tag, i),
                  got_q[i].word, exp_q[i].word);
            check($sformatf("%s w%0d keep", tag, i),
                  64'(got_q[i].keep), 64'(exp_q[i].keep));
            check($sformatf("%s w%0d last", tag, i),
                  64'(got_q[i].last), 64'(exp_q[i].last));
            if (exp_q[i].last) begin
                check($sformatf("%s w%0d fcs", tag, i),
                      64'(got_q[i].fcs), 64'(exp_q[i].fcs));
                check($sformatf("%s w%0d abort", tag, i),
                      64'(got_q[i].abort), 64'(exp_q[i].abort));
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " m_valid"}, 64'(m_valid), 64'd0);
        check({tag, " m_word"}, m_word, 64'd0);
        check({tag, " m_keep"}, 64'(m_keep), 64'd0);
        check({tag, " m_last"}, 64'(m_last), 64'd0);
        check({tag, " m_fcs_ok"}, 64'(m_fcs_ok), 64'd0);
        check({tag, " m_abort"}, 64'(m_abort), 64'd0);
        check({tag, " overflow"}, 64'(overflow_err), 64'd0);
    endtask

    initial begin
        ent_t        e;
        int          len;
        int          nb;
        logic        ab;
        logic        same;
        logic        okv;
        logic        pkt_open;
        logic [63:0] w0;

        rst_n       = 1'b0;
        hdr_strobe  = 1'b0;
        hdr_valid   = 1'b0;
        pkt_len     = '0;
        byte_strobe = 1'b0;
        byte_out    = '0;
        fcs_strobe  = 1'b0;
        fcs_ok      = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 16-byte packet, plus two-cycle latency after the FCS event
        send_header(1'b1, 16'd16);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        check("lat +1 m_valid", 64'(m_valid), 64'd0);
        tick();
        check("lat +2 m_valid", 64'(m_valid), 64'd1);
        check("lat +2 m_last", 64'(m_last), 64'd1);
        model_close(1'b0, 1'b1);
        compare("pkt16");

        // 11-byte packet, partial last word, FCS failure
        send_header(1'b1, 16'd11);
        for (int i = 0; i < 11; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
        tick();
        send_fcs(1'b0);
        model_close(1'b0, 1'b0);
        compare("pkt11");

        // Abort after 5 bytes, then a normal packet
        send_header(1'b1, 16'd20);
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b0);
        model_close(1'b1, 1'b0);
        send_header(1'b1, 16'd9);
        for (int i = 0; i < 9; i++) send_byte(8'h50 + 8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        model_close(1'b0, 1'b1);
        compare("abort");

        // Invalid and zero-length headers are ignored, as are stray strobes
        send_header(1'b0, 16'd8);
        for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        send_header(1'b1, 16'd0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_fcs(1'b0);
        pb.delete();
        check("badhdr m_valid", 64'(m_valid), 64'd0);
        compare("badhdr");
        send_header(1'b1, 16'd3);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        model_close(1'b0, 1'b1);
        compare("after badhdr");

        // Overflow: six full words with the consumer stalled
        ready_fixed = 1'b0;
        repeat (2) tick();
        send_header(1'b1, 16'd56);
        for (int i = 0; i < 48; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        repeat (4) tick();
        check("ovf set", 64'(overflow_err), 64'd1);
        w0 = '0;
        for (int j = 0; j < WB; j++) w0[8*j +: 8] = pb[j];
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall %0d m_valid", k), 64'(m_valid), 64'd1);
            check($sformatf("stall %0d m_word", k), m_word, w0);
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            e.word = '0;
            for (int j = 0; j < WB; j++) e.word[8*j +: 8] = pb[w*WB+j];
            e.keep  = 8'hFF;
            e.last  = 1'b0;
            e.fcs   = 1'b0;
            e.abort = 1'b0;
            exp_q.push_back(e);
        end
        e.word  = '0;
        e.keep  = '0;
        e.last  = 1'b1;
        e.fcs   = 1'b0;
        e.abort = 1'b1;
        exp_q.push_back(e);
        pb.delete();
        ready_fixed = 1'b1;
        repeat (10) tick();
        send_header(1'b1, 16'd8);
        check("ovf cleared", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        send_fcs(1'b1);
        model_close(1'b0, 1'b1);
        compare("overflow");

        // Reset mid-packet with a word still waiting at the output
        ready_fixed = 1'b0;
        repeat (2) tick();
        send_header(1'b1, 16'd8);
        for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        send_header(1'b1, 16'd8);
        for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i), 1'b0, 1'b0);
        pb.delete();
        tick();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        tick();
        rst_n = 1'b1;
        ready_fixed = 1'b1;
        repeat (2) tick();
        send_header(1'b1, 16'd12);
        for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0);
        send_fcs(1'b0);
        model_close(1'b0, 1'b0);
        compare("post reset");

        // Random packets, random aborts, random consumer stalls
        rand_ready = 1'b1;
        pkt_open = 1'b0;
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 40);
            if (pkt_open) model_close(1'b1, 1'b0);
            send_header(1'b1, 16'(len));
            ab = (it < 24) && ($urandom_range(0, 4) == 0);
            nb = ab ? $urandom_range(0, len - 1) : len;
            same = 1'b0;
            okv = 1'($urandom_range(0, 1));
            for (int k = 0; k < nb; k++) begin
                same = (k == len - 1) && ($urandom_range(0, 1) == 1);
                send_byte(8'($urandom), same, okv);
                if (k != len - 1 && $urandom_range(0, 3) == 0) tick();
            end
            if (!ab) begin
                if (!same) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_fcs(okv);
                end
                model_close(1'b0, okv);
            end
            pkt_open = ab;
        end
        compare("random");
        check("random ovf", 64'(overflow_err), 64'd0);
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_byte_packer.md
RX_BYTE_PACKER -- requirements
Module: rx_byte_packer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 8, bytes per output word (power of 2, 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries (power of 2, >=2).
REQ-003 SHALL have port s00_axi_aclk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pkt_header_valid_strobe  in  1  header decode strobe from receiver core.
REQ-006 SHALL have port pkt_header_valid  in  1  header decoded OK; sampled with the strobe.
REQ-007 SHALL have port pkt_len  in  16  PSDU length in bytes; sampled with the strobe.
REQ-008 SHALL have port byte_out_strobe  in  1  one decoded byte valid.
REQ-009 SHALL have port byte_out  in  8  decoded byte.
REQ-010 SHALL have port fcs_out_strobe  in  1  FCS check result valid.
REQ-011 SHALL have port fcs_ok  in  1  FCS pass; sampled with fcs_out_strobe.
REQ-012 SHALL have port m_word  out  8*WORD_BYTES  packed word, first byte in bits [7:0].
REQ-013 SHALL have port m_keep  out  WORD_BYTES  byte-enable, contiguous from bit 0.
REQ-014 SHALL have port m_last  out  1  final word of packet.
REQ-015 SHALL have port m_fcs_ok  out  1  FCS result; meaningful only with m_last.
REQ-016 SHALL have port m_abort  out  1  packet truncated; meaningful only with m_last.
REQ-017 SHALL have ports m_valid out 1 / m_ready in 1  output handshake; transfer when both high.
REQ-018 SHALL have port overflow_err  out  1  sticky: a word was dropped because FIFO was full.

Function
REQ-019 SHALL implement states IDLE, COLLECT, WAIT_FCS.
REQ-020 IDLE->COLLECT on header strobe with pkt_header_valid=1 and pkt_len!=0; latch pkt_len, clear byte counter, lane index, overflow_err.
REQ-021 Header strobe with pkt_header_valid=0 or pkt_len=0 SHALL leave state IDLE, no output.
REQ-022 In COLLECT each byte strobe SHALL write byte_out into lane = byte_count mod WORD_BYTES and increment byte_count (16 bit).
REQ-023 When a lane write fills the word and byte_count+1 < pkt_len, full word SHALL be pushed next cycle, m_keep all ones, m_last=0.
REQ-024 When byte_count+1 == pkt_len, the (possibly partial) word SHALL be held, not pushed; state->WAIT_FCS.
REQ-025 In WAIT_FCS, fcs_out_strobe SHALL push held word with m_last=1, m_fcs_ok=fcs_ok, m_abort=0, keep = ones for occupied lanes; state->IDLE.
REQ-026 fcs_out_strobe in the same cycle as the final byte SHALL be honoured as in REQ-025 (word pushed next cycle).
REQ-027 Byte strobes in IDLE or WAIT_FCS SHALL be ignored; fcs_out_strobe in IDLE or COLLECT SHALL be ignored.
REQ-028 Valid header strobe while in COLLECT or WAIT_FCS SHALL push current word (keep = occupied lanes; single m_keep=0 word if none) with m_last=1, m_abort=1, m_fcs_ok=0, then start new packet per REQ-020 same cycle.
REQ-029 Unused lanes of a partial word SHALL be zero.
REQ-030 Push when FIFO full SHALL drop the word, set overflow_err; packer state SHALL continue unaffected.
REQ-031 FIFO SHALL allow simultaneous push and pop when full (pop frees slot same cycle).
REQ-032 Latency: final byte/fcs event to m_valid high SHALL be 2 cycles with empty FIFO (1 push register + 1 FIFO read register).
REQ-033 m_word/m_keep/m_last/m_fcs_ok/m_abort SHALL be stable while m_valid=1 and m_ready=0.

Reset
REQ-034 On s00_axi_aresetn low: state IDLE, counters 0, FIFO empty, m_valid=0, m_word=0, m_keep=0, m_last=0, m_fcs_ok=0, m_abort=0, overflow_err=0.
REQ-035 Reset mid-packet SHALL discard partial word without emitting any output.

Structure
REQ-036 State encoding and WORD_BYTES/FIFO_DEPTH defaults SHALL live in shared package rx_byte_packer_pkg.
REQ-037 FIFO SHALL be sub-module rx_word_fifo (width 8*WORD_BYTES+WORD_BYTES+3, depth FIFO_DEPTH, first-word-fall-through registered output).

Verification
REQ-038 pkt_len=16, bytes 0x00..0x0F, fcs_ok=1, m_ready=1 -> 2 words 0x0706050403020100 keep 0xFF last 0, 0x0F0E0D0C0B0A0908 keep 0xFF last 1 fcs_ok 1.
REQ-039 pkt_len=11, bytes 0xA0..0xAA, fcs_ok=0 -> word 2 = 0x0000000000AAA9A8, keep 0x07, last 1, fcs_ok 0.
REQ-040 pkt_len=20, new valid header after 5 bytes -> word keep 0x1F, last 1, abort 1; second packet decodes normally.
REQ-041 m_ready=0, 6 full words pushed, FIFO_DEPTH=4 -> 4 words retained in order, overflow_err=1, cleared at next valid header.
REQ-042 header pkt_header_valid=0, then 8 byte strobes -> no m_valid, state IDLE.
REQ-043 reset asserted after 3 bytes of pkt_len=8 -> all outputs 0; following packet emits exactly its own words.
